// File: rtl/mt9v032_pkg.sv
// Shared constants, state encoding and pixel clamp helper for the MT9V032
// serial word stream (used by both the transmitter and the deserializer).
package mt9v032_pkg;
    localparam int WORD_W = 12;
    localparam int DATA_W = 10;
    localparam logic [3:0] LAST_BIT = 4'(WORD_W - 1);

    localparam logic [DATA_W-1:0] SYNC_HI = 10'h3FF;
    localparam logic [DATA_W-1:0] SYNC_LO = 10'h000;

    localparam logic [DATA_W-1:0] DEF_CODE_LS = 10'h001;
    localparam logic [DATA_W-1:0] DEF_CODE_LE = 10'h002;
    localparam logic [DATA_W-1:0] DEF_CODE_FS = 10'h004;
    localparam logic [DATA_W-1:0] DEF_CODE_FE = 10'h008;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOS0,
        ST_SOS1,
        ST_SOS2,
        ST_PIX,
        ST_EOS0,
        ST_EOS1,
        ST_EOS2
    } tx_state_e;

    // Keeps pixel words from aliasing the reserved all-zero/all-one sync values.
    function automatic logic [DATA_W-1:0] clamp_pixel(input logic [DATA_W-1:0] d,
                                                      input logic en);
        logic [DATA_W-1:0] r;
        r = d;
        if (en && d == SYNC_LO) begin
            r = 10'h001;
        end else if (en && d == SYNC_HI) begin
            r = 10'h3FE;
        end
        return r;
    endfunction
endpackage

// File: rtl/mt9v032_serial_shifter.sv
// 12-bit load/shift register: start bit, 10 data bits LSB first, stop bit.
// Loads a new word at every boundary (bit_cnt at its last bit).
module mt9v032_serial_shifter
    import mt9v032_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] load_data,
    output logic              boundary,
    output logic              ser_out,
    output logic              word_start
);
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic              word_start_q, word_start_d;

    assign boundary = (bit_cnt_q == LAST_BIT);

    always_comb begin
        if (boundary) begin
            shreg_d   = {1'b0, load_data, 1'b1};
            bit_cnt_d = 4'd0;
        end else begin
            shreg_d   = {1'b0, shreg_q[WORD_W-1:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
        end
        word_start_d = boundary;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q      <= '0;
            bit_cnt_q    <= LAST_BIT;
            word_start_q <= 1'b0;
        end else begin
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            word_start_q <= word_start_d;
        end
    end

    assign ser_out    = shreg_q[0];
    assign word_start = word_start_q;
endmodule

// File: rtl/mt9v032_serial_tx.sv
// MT9V032 bit-serial transmitter: one-entry pixel register plus word-sequencing
// FSM wrapping line pixels in 3-word start/end sync sequences.
module mt9v032_serial_tx
    import mt9v032_pkg::*;
#(
    parameter bit                CLAMP   = 1'b1,
    parameter logic [DATA_W-1:0] CODE_LS = DEF_CODE_LS,
    parameter logic [DATA_W-1:0] CODE_LE = DEF_CODE_LE,
    parameter logic [DATA_W-1:0] CODE_FS = DEF_CODE_FS,
    parameter logic [DATA_W-1:0] CODE_FE = DEF_CODE_FE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_fs,
    input  logic              in_ls,
    input  logic              in_le,
    input  logic              in_fe,
    output logic              ser_out,
    output logic              word_start,
    output logic              busy
);
    tx_state_e         state_q, state_d, nxt_state;
    logic              pend_valid_q, pend_valid_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic              pend_fs_q, pend_fs_d, pend_ls_q, pend_ls_d;
    logic              pend_le_q, pend_le_d, pend_fe_q, pend_fe_d;
    logic              cur_le_q, cur_le_d, cur_fe_q, cur_fe_d;
    logic              busy_q, busy_d;
    logic              in_ready_q, in_ready_d;
    logic [DATA_W-1:0] word_d;
    logic              boundary, load_pix, idle_like, accept;

    always_comb begin
        nxt_state = state_q;
        word_d    = SYNC_LO;
        load_pix  = 1'b0;
        idle_like = 1'b0;
        case (state_q)
            ST_SOS0: begin word_d = SYNC_LO; nxt_state = ST_SOS1; end
            ST_SOS1: begin
                word_d    = CODE_LS | (pend_fs_q ? CODE_FS : '0);
                nxt_state = ST_SOS2;
            end
            ST_SOS2: load_pix = 1'b1;
            ST_PIX: begin
                if (cur_le_q) begin
                    word_d    = SYNC_HI;
                    nxt_state = ST_EOS0;
                end else begin
                    idle_like = 1'b1;
                end
            end
            ST_EOS0: begin word_d = SYNC_LO; nxt_state = ST_EOS1; end
            ST_EOS1: begin
                word_d    = CODE_LE | (cur_fe_q ? CODE_FE : '0);
                nxt_state = ST_EOS2;
            end
            default: idle_like = 1'b1;
        endcase
        if (idle_like) begin
            if (pend_valid_q && pend_ls_q) begin
                word_d    = SYNC_HI;
                nxt_state = ST_SOS0;
            end else if (pend_valid_q) begin
                load_pix = 1'b1;
            end else begin
                word_d    = SYNC_LO;
                nxt_state = ST_IDLE;
            end
        end
        if (load_pix) begin
            word_d    = clamp_pixel(pend_data_q, CLAMP);
            nxt_state = ST_PIX;
        end

        state_d  = state_q;
        cur_le_d = cur_le_q;
        cur_fe_d = cur_fe_q;
        busy_d   = busy_q;
        if (boundary) begin
            state_d = nxt_state;
            busy_d  = (nxt_state != ST_IDLE);
            if (load_pix) begin
                cur_le_d = pend_le_q;
                cur_fe_d = pend_fe_q;
            end
        end

        // Accept and load are exclusive: accept needs an empty pend, load a full one.
        accept       = in_valid && in_ready_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        pend_fs_d    = pend_fs_q;
        pend_ls_d    = pend_ls_q;
        pend_le_d    = pend_le_q;
        pend_fe_d    = pend_fe_q;
        if (boundary && load_pix) begin
            pend_valid_d = 1'b0;
        end else if (accept) begin
            pend_valid_d = 1'b1;
            pend_data_d  = in_data;
            pend_fs_d    = in_fs;
            pend_ls_d    = in_ls;
            pend_le_d    = in_le;
            pend_fe_d    = in_fe;
        end
        in_ready_d = !pend_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            pend_fs_q    <= 1'b0;
            pend_ls_q    <= 1'b0;
            pend_le_q    <= 1'b0;
            pend_fe_q    <= 1'b0;
            cur_le_q     <= 1'b0;
            cur_fe_q     <= 1'b0;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            pend_fs_q    <= pend_fs_d;
            pend_ls_q    <= pend_ls_d;
            pend_le_q    <= pend_le_d;
            pend_fe_q    <= pend_fe_d;
            cur_le_q     <= cur_le_d;
            cur_fe_q     <= cur_fe_d;
            busy_q       <= busy_d;
            in_ready_q   <= in_ready_d;
        end
    end

    mt9v032_serial_shifter u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load_data  (word_d),
        .boundary   (boundary),
        .ser_out    (ser_out),
        .word_start (word_start)
    );

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_mt9v032_serial_tx.sv
// Scoreboard bench: two transmitters (CLAMP=1 and CLAMP=0) share one input
// stream; per-instance monitors deserialize words and pop expected values.
module tb_mt9v032_serial_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [9:0] in_data = '0;
    logic       in_fs = 1'b0, in_ls = 1'b0, in_le = 1'b0, in_fe = 1'b0;
    logic       ser_o [2];
    logic       ws_o [2];
    logic       busy_o [2];
    logic       rdy_o [2];

    logic [9:0] q0[$];
    logic [9:0] q1[$];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mt9v032_serial_tx #(.CLAMP(g == 0)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid),
            .in_ready   (rdy_o[g]),
            .in_data    (in_data),
            .in_fs      (in_fs),
            .in_ls      (in_ls),
            .in_le      (in_le),
            .in_fe      (in_fe),
            .ser_out    (ser_o[g]),
            .word_start (ws_o[g]),
            .busy       (busy_o[g])
        );
    end

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_both(input logic [9:0] a, input logic [9:0] b);
        q0.push_back(a);
        q1.push_back(b);
    endtask

    task automatic push_pix(input logic [9:0] d, input logic fs, ls, le, fe);
        logic [9:0] cl;
        if (ls) begin
            push_both(10'h3FF, 10'h3FF);
            push_both(10'h000, 10'h000);
            push_both(fs ? 10'h005 : 10'h001, fs ? 10'h005 : 10'h001);
        end
        cl = (d == 10'h000) ? 10'h001 : (d == 10'h3FF) ? 10'h3FE : d;
        push_both(cl, d);
        if (le) begin
            push_both(10'h3FF, 10'h3FF);
            push_both(10'h000, 10'h000);
            push_both(fe ? 10'h00A : 10'h002, fe ? 10'h00A : 10'h002);
        end
    endtask

    task automatic monitor(input int idx);
        logic [11:0] w;
        logic [9:0]  data, exp;
        logic        bsy, rdy_bnd, prev_rdy, in_sync, aborted, ws_extra, has;
        prev_rdy = 1'b1;
        in_sync  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_sync  = 1'b0;
                prev_rdy = 1'b1;
                continue;
            end
            if (in_sync) check(ws_o[idx] == 1'b1, $sformatf("dut%0d ws_cadence", idx), 32'(ws_o[idx]), 1);
            if (!ws_o[idx]) begin
                in_sync = 1'b0;
                continue;
            end
            bsy = busy_o[idx];
            w[0] = ser_o[idx];
            aborted  = 1'b0;
            ws_extra = 1'b0;
            for (int b = 1; b < 12; b++) begin
                @(negedge clk);
                if (rst) begin
                    aborted = 1'b1;
                    break;
                end
                w[b] = ser_o[idx];
                if (ws_o[idx]) ws_extra = 1'b1;
            end
            if (aborted) begin
                in_sync  = 1'b0;
                prev_rdy = 1'b1;
                continue;
            end
            rdy_bnd = rdy_o[idx];
            in_sync = 1'b1;
            data    = w[10:1];
            check({ws_extra, w[11], w[0]} == 3'b001, $sformatf("dut%0d framing", idx),
                  32'({ws_extra, w[11], w[0]}), 32'b001);
            if (bsy) begin
                has = 1'b0;
                exp = '0;
                if (idx == 0) begin
                    has = (q0.size() != 0);
                    if (has) exp = q0.pop_front();
                end else begin
                    has = (q1.size() != 0);
                    if (has) exp = q1.pop_front();
                end
                check(has, $sformatf("dut%0d unexpected_word", idx), 32'(data), 0);
                if (has) check(data == exp, $sformatf("dut%0d word", idx), 32'(data), 32'(exp));
            end else begin
                check(data == 10'h000, $sformatf("dut%0d idle_data", idx), 32'(data), 0);
                check(prev_rdy, $sformatf("dut%0d idle_with_pend", idx), 32'(prev_rdy), 1);
            end
            prev_rdy = rdy_bnd;
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic send(input logic [9:0] d, input logic fs, ls, le, fe, input bit model);
        int budget;
        @(negedge clk);
        in_data  = d;
        in_fs    = fs;
        in_ls    = ls;
        in_le    = le;
        in_fe    = fe;
        in_valid = 1'b1;
        budget   = 0;
        while (!rdy_o[0] && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check(rdy_o[0] == 1'b1, "handshake", 32'(rdy_o[0]), 1);
        if (model && rdy_o[0]) push_pix(d, fs, ls, le, fe);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((q0.size() != 0 || q1.size() != 0) && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        check(q0.size() == 0 && q1.size() == 0, "drain", 32'(q0.size() + q1.size()), 0);
        repeat (30) @(negedge clk);
    endtask

    initial begin
        int budget;
        logic [9:0] d;
        repeat (3) @(negedge clk);
        check({ser_o[0], ws_o[0], busy_o[0], rdy_o[0]} == 4'b0000, "reset_outputs",
              32'({ser_o[0], ws_o[0], busy_o[0], rdy_o[0]}), 0);
        rst = 1'b0;
        @(negedge clk);
        check({ws_o[0], ser_o[0], rdy_o[0]} == 3'b111, "first_start",
              32'({ws_o[0], ser_o[0], rdy_o[0]}), 32'b111);
        repeat (40) @(negedge clk);

        // Single pixel carrying every marker.
        push_both(10'h3FF, 10'h3FF); push_both(10'h000, 10'h000); push_both(10'h005, 10'h005);
        push_both(10'h155, 10'h155);
        push_both(10'h3FF, 10'h3FF); push_both(10'h000, 10'h000); push_both(10'h00A, 10'h00A);
        send(10'h155, 1, 1, 1, 1, 0);
        drain();

        // Four-pixel line, in_valid held; CLAMP=1 vs CLAMP=0 words.
        push_both(10'h3FF, 10'h3FF); push_both(10'h000, 10'h000); push_both(10'h001, 10'h001);
        push_both(10'h001, 10'h000); push_both(10'h3FE, 10'h3FF);
        push_both(10'h200, 10'h200); push_both(10'h001, 10'h001);
        push_both(10'h3FF, 10'h3FF); push_both(10'h000, 10'h000); push_both(10'h002, 10'h002);
        send(10'h000, 0, 1, 0, 0, 0);
        send(10'h3FF, 0, 0, 0, 0, 0);
        send(10'h200, 0, 0, 0, 0, 0);
        send(10'h001, 0, 0, 1, 0, 0);
        drain();

        // Reset in the middle of the SOS1 word.
        push_both(10'h3FF, 10'h3FF);
        send(10'h0AA, 1, 1, 0, 0, 0);
        budget = 0;
        while (!(ws_o[0] && busy_o[0]) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check(ws_o[0] && busy_o[0], "sos0_found", 32'(busy_o[0]), 1);
        repeat (12) @(negedge clk);
        check(ws_o[0] && busy_o[0], "sos1_start", 32'({ws_o[0], busy_o[0]}), 3);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check({ser_o[0], ws_o[0], busy_o[0], rdy_o[0]} == 4'b0000, "mid_reset_outputs",
              32'({ser_o[0], ws_o[0], busy_o[0], rdy_o[0]}), 0);
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check({ws_o[0], ser_o[0], busy_o[0]} == 3'b110, "restart",
              32'({ws_o[0], ser_o[0], busy_o[0]}), 32'b110);
        repeat (60) @(negedge clk);

        push_both(10'h3FF, 10'h3FF); push_both(10'h000, 10'h000); push_both(10'h005, 10'h005);
        push_both(10'h123, 10'h123);
        push_both(10'h3FF, 10'h3FF); push_both(10'h000, 10'h000); push_both(10'h00A, 10'h00A);
        send(10'h123, 1, 1, 1, 1, 0);
        drain();

        // Randomly gapped stream of 1000 pixels with sparse markers.
        for (int i = 0; i < 1000; i++) begin
            d = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 7) == 0) d = $urandom_range(0, 1) ? 10'h3FF : 10'h000;
            send(d, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
